// File: rtl/avalon_wait_ram.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module     : avalon_wait_ram                                             |
// | Description: Avalon-MM slave word memory that stalls each access for a   |
// |              programmable number of waitrequest cycles. It supports      |
// |              per-byte write enables, a side preload port, and a sticky   |
// |              flag for master protocol violations.                        |
// | Revision   : 1.0  - initial release                                      |
// +--------------------------------------------------------------------------+
// | Ports                                                                    |
// |   clk            in   1   rising-edge clock                              |
// |   reset          in   1   synchronous active-high, handshake logic only  |
// |   address        in  32   byte address, word = address[ADDR_W+1:2]      |
// |   read / write   in   1   Avalon request strobes                         |
// |   writedata      in  32   write data                                     |
// |   byteenable     in   4   per-byte write enables                         |
// |   waitrequest    out  1   combinational stall                            |
// |   readdata       out 32   registered read data                           |
// |   instruction    in  32   preload word                                   |
// |   inst_input     in   1   preload enable                                 |
// |   inst_addr      in   8   preload byte address, word = inst_addr[7:2]    |
// |   protocol_error out  1   sticky protocol violation flag                 |
// +--------------------------------------------------------------------------+
module avalon_wait_ram #(
  parameter int ADDR_W      = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] address,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  input  logic [3:0]  byteenable,
  output logic        waitrequest,
  output logic [31:0] readdata,
  input  logic [31:0] instruction,
  input  logic        inst_input,
  input  logic [7:0]  inst_addr,
  output logic        protocol_error
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [3:0] C_WAIT = 4'(WAIT_CYCLES);

  logic [31:0] mem [2**ADDR_W];

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              type_q, type_d;     // 1 = write access
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [31:0]       readdata_q;
  logic              perr_q, perr_d;

  logic              w_req;
  logic              w_both;
  logic [ADDR_W-1:0] w_bus_idx;
  logic [ADDR_W-1:0] w_pre_idx;
  logic              w_rd_fire;
  logic [ADDR_W-1:0] w_rd_idx;
  logic              w_wr_commit;
  logic              w_pre_hit;
  logic              unused_bits;

  assign w_req     = read | write;
  assign w_both    = read & write;
  assign w_bus_idx = address[ADDR_W+1:2];
  assign w_pre_idx = ADDR_W'(inst_addr[7:2]);
  // Preload beats a bus write to the same word on the same edge.
  assign w_pre_hit = inst_input && (w_pre_idx == idx_q);

  assign unused_bits = ^{address[31:ADDR_W+2], address[1:0], inst_addr[1:0]};

  assign waitrequest    = w_req && (state_q != S_DONE);
  assign readdata       = readdata_q;
  assign protocol_error = perr_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    type_d      = type_q;
    idx_d       = idx_q;
    perr_d      = perr_q;
    w_rd_fire   = 1'b0;
    w_rd_idx    = idx_q;
    w_wr_commit = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (w_both) begin
          // Ambiguous request is refused; keep stalling until it clears.
          perr_d = 1'b1;
        end else if (w_req) begin
          cnt_d  = C_WAIT;
          type_d = write;
          idx_d  = w_bus_idx;
          if (WAIT_CYCLES == 0) begin
            state_d   = S_DONE;
            w_rd_fire = read;
            w_rd_idx  = w_bus_idx;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        // Master must hold the same request stable while stalled.
        if (!w_req || w_both || (write != type_q) || (w_bus_idx != idx_q)) begin
          state_d = S_IDLE;
          perr_d  = 1'b1;
        end else if (cnt_q <= 4'd1) begin
          state_d   = S_DONE;
          w_rd_fire = !type_q;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_DONE: begin
        state_d     = S_IDLE;
        w_wr_commit = type_q;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= 4'd0;
      type_q     <= 1'b0;
      idx_q      <= '0;
      readdata_q <= 32'd0;
      perr_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      type_q  <= type_d;
      idx_q   <= idx_d;
      perr_q  <= perr_d;
      if (w_rd_fire) begin
        readdata_q <= mem[w_rd_idx];
      end
    end
  end

  // Storage is never reset; a reset only suppresses a pending bus write.
  always_ff @(posedge clk) begin
    if (inst_input) begin
      mem[w_pre_idx] <= instruction;
    end
    if (w_wr_commit && !reset && !w_pre_hit) begin
      for (int b = 0; b < 4; b++) begin
        if (byteenable[b]) begin
          mem[idx_q][8*b +: 8] <= writedata[8*b +: 8];
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_avalon_wait_ram.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module     : tb_avalon_wait_ram                                          |
// | Description: Directed self-checking bench for avalon_wait_ram. Two       |
// |              instances: WAIT_CYCLES=2 (dut0) and WAIT_CYCLES=0 (dut1).   |
// |              Expected read data is queued at issue and popped on DONE.   |
// | Revision   : 1.0  - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_avalon_wait_ram;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] address;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic [31:0] instruction;
  logic        inst_input;
  logic [7:0]  inst_addr;
  logic        rd0, wr0, rd1, wr1;
  logic        wreq0, wreq1, perr0, perr1;
  logic [31:0] rdata0, rdata1;

  int          tests = 0;
  int          fails = 0;
  logic [31:0] sb [$];

  always #5 clk = ~clk;

  avalon_wait_ram #(.ADDR_W(8), .WAIT_CYCLES(2)) dut0 (
    .clk(clk), .reset(reset), .address(address), .read(rd0), .write(wr0),
    .writedata(writedata), .byteenable(byteenable), .waitrequest(wreq0),
    .readdata(rdata0), .instruction(instruction), .inst_input(inst_input),
    .inst_addr(inst_addr), .protocol_error(perr0)
  );

  avalon_wait_ram #(.ADDR_W(8), .WAIT_CYCLES(0)) dut1 (
    .clk(clk), .reset(reset), .address(address), .read(rd1), .write(wr1),
    .writedata(writedata), .byteenable(byteenable), .waitrequest(wreq1),
    .readdata(rdata1), .instruction(instruction), .inst_input(inst_input),
    .inst_addr(inst_addr), .protocol_error(perr1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Preload one word; entered and left at posedge+1.
  task automatic preload(input logic [7:0] a, input logic [31:0] d);
    inst_addr   = a;
    instruction = d;
    inst_input  = 1'b1;
    @(posedge clk); #1;
    inst_input  = 1'b0;
  endtask

  // One complete access; entered and left at posedge+1 so calls chain back-to-back.
  // For reads, d is the expected read data.
  task automatic do_access(input int sel, input bit is_wr, input logic [31:0] a,
                           input logic [31:0] d, input logic [3:0] b, input string tag);
    int          hi;
    int          lat;
    logic        w;
    logic [31:0] exp;
    lat        = (sel == 0) ? 3 : 1;
    address    = a;
    writedata  = is_wr ? d : 32'h0;
    byteenable = b;
    if (sel == 0) begin rd0 = !is_wr; wr0 = is_wr; end
    else          begin rd1 = !is_wr; wr1 = is_wr; end
    if (!is_wr) sb.push_back(d);
    hi = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      w = (sel == 0) ? wreq0 : wreq1;
      if (w) hi++;
      else break;
    end
    chk({tag, "_latency"}, 32'(hi), 32'(lat));
    if (!is_wr) begin
      exp = sb.pop_front();
      chk({tag, "_rdata"}, (sel == 0) ? rdata0 : rdata1, exp);
    end
    @(posedge clk); #1;
    rd0 = 1'b0; wr0 = 1'b0; rd1 = 1'b0; wr1 = 1'b0;
  endtask

  initial begin
    int hi;
    reset = 1'b1; address = '0; writedata = '0; byteenable = '0;
    instruction = '0; inst_input = 1'b0; inst_addr = '0;
    rd0 = 1'b0; wr0 = 1'b0; rd1 = 1'b0; wr1 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    // Test 1: preload while reset is held
    preload(8'h04, 32'h24032468);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_wreq0", 32'(wreq0), 32'd0);
    chk("rst_rdata0", rdata0, 32'd0);
    chk("rst_perr0", 32'(perr0), 32'd0);
    chk("rst_wreq1", 32'(wreq1), 32'd0);
    chk("rst_rdata1", rdata1, 32'd0);
    @(posedge clk); #1;
    do_access(0, 1'b0, 32'h04, 32'h24032468, 4'hF, "t1_rd");

    // Test 2: byte-enabled write over preloaded word
    preload(8'h08, 32'hFFFFFFFF);
    do_access(0, 1'b1, 32'h08, 32'h12345678, 4'b0101, "t2_wr");
    do_access(0, 1'b0, 32'h08, 32'hFF34FF78, 4'hF, "t2_rd");

    // Test 3: back-to-back write then read, both wait settings
    do_access(0, 1'b1, 32'h0C, 32'hAAAA5555, 4'hF, "t3_wr_w2");
    do_access(0, 1'b0, 32'h0C, 32'hAAAA5555, 4'hF, "t3_rd_w2");
    do_access(1, 1'b1, 32'h0C, 32'hAAAA5555, 4'hF, "t3_wr_w0");
    do_access(1, 1'b0, 32'h0C, 32'hAAAA5555, 4'hF, "t3_rd_w0");
    chk("t3_perr1", 32'(perr1), 32'd0);

    // Test 4: read and write together, then write alone
    preload(8'h10, 32'h5A5A0000);
    address = 32'h10; writedata = 32'h11111111; byteenable = 4'hF;
    rd0 = 1'b1; wr0 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t4_both_wreq", 32'(wreq0), 32'd1);
    end
    chk("t4_perr_set", 32'(perr0), 32'd1);
    @(posedge clk); #1;
    do_access(0, 1'b1, 32'h10, 32'hCAFEF00D, 4'b0011, "t4_wr");
    chk("t4_perr_sticky", 32'(perr0), 32'd1);
    do_access(0, 1'b0, 32'h10, 32'h5A5AF00D, 4'hF, "t4_rd");

    // Test 5: reset during the WAIT state of a write
    preload(8'h14, 32'h00000000);
    address = 32'h14; writedata = 32'hDEADBEEF; byteenable = 4'hF;
    wr0 = 1'b1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; wr0 = 1'b0;
    @(negedge clk);
    chk("t5_rdata_clr", rdata0, 32'd0);
    chk("t5_perr_clr", 32'(perr0), 32'd0);
    chk("t5_wreq", 32'(wreq0), 32'd0);
    @(posedge clk); #1;
    do_access(0, 1'b0, 32'h14, 32'h00000000, 4'hF, "t5_rd");

    // Test 6: preload and bus write collide on the DONE edge
    address = 32'h18; writedata = 32'h11111111; byteenable = 4'hF;
    wr0 = 1'b1;
    hi = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (wreq0) hi++;
      else break;
    end
    chk("t6_latency", 32'(hi), 32'd3);
    inst_addr = 8'h18; instruction = 32'h22222222; inst_input = 1'b1;
    @(posedge clk); #1;
    inst_input = 1'b0; wr0 = 1'b0;
    do_access(0, 1'b0, 32'h18, 32'h22222222, 4'hF, "t6_rd");
    chk("t6_perr", 32'(perr0), 32'd0);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/avalon_wait_ram.md
Name: avalon_wait_ram

Overview:
- Avalon-MM slave memory on the data/instruction side of top_level_CPU. It directly consumes the CPU's bus master transactions.
- Inserts a programmable number of waitrequest stall cycles per access so the CPU's stall handling is exercised.
- Supports per-byte write enables.
- Has a bench-side preload port for placing programs before and during reset.
- Memory contents survive reset. Only the handshake logic is reset.

Parameters:
- ADDR_W, 8: word-address width; memory holds 2**ADDR_W 32-bit words.
- WAIT_CYCLES, 2: extra stall cycles per access, legal range 0..15.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high; returns handshake FSM to IDLE.
- address  input  32  byte address; word index = address[ADDR_W+1:2]; address[1:0] and upper bits ignored.
- read  input  1  Avalon read request.
- write  input  1  Avalon write request.
- writedata  input  32  write data.
- byteenable  input  4  bit i enables writedata[8i+7:8i].
- waitrequest  output  1  slave stall; combinational.
- readdata  output  32  registered read data.
- instruction  input  32  preload word.
- inst_input  input  1  preload enable.
- inst_addr  input  8  preload byte address; word index = inst_addr[7:2], zero-extended to ADDR_W.
- protocol_error  output  1  sticky master-protocol violation flag.

Behaviour:
- States: IDLE, WAIT, DONE. Let req = read | write.
- Reset values: state IDLE, wait counter 0, readdata 0, protocol_error 0. waitrequest = 0 while no req.
- waitrequest = req && (state != DONE).
- IDLE:
  - On req (read XOR write), load counter = WAIT_CYCLES and latch the request type and word index.
  - If WAIT_CYCLES == 0, go to DONE, else go to WAIT.
- WAIT:
  - Counter decrements each cycle; when the counter reaches 1, the next state is DONE.
  - If req drops or the latched type/index changes, go to IDLE, set protocol_error, commit no write.
- DONE: waitrequest low for exactly this one cycle.
  - Read: readdata holds mem[index], captured on the edge entering DONE. It holds that value until the next read enters DONE.
  - Write: the enabled bytes commit on the edge leaving DONE; disabled bytes are unchanged.
  - Next state is always IDLE.
- Latency: waitrequest is high for WAIT_CYCLES+1 cycles from the first req cycle, then low for 1 cycle. A total of WAIT_CYCLES+2 cycles per access.
- Back-to-back: a request presented in the cycle after DONE is accepted from IDLE normally. There is no extra turnaround.
- read && write together in IDLE:
  - The request is not accepted, protocol_error is set, and waitrequest stays high.
  - The FSM stays in IDLE until the condition clears.
- byteenable == 0 on a write completes the handshake normally with no memory change.
- Preload:
  - When inst_input = 1, mem[inst_addr[7:2]] <= instruction on each edge.
  - This works regardless of reset or FSM state.
  - Same-edge collision with a bus write to the same word: preload wins entirely.
- Reset mid-access: next state is IDLE and any pending write is discarded. readdata is cleared to 0, protocol_error is cleared, memory is untouched.
- Memory has no reset. Locations never written read as X in simulation.

Test Plan:
1. Preload 0x24032468 at inst_addr 0x04 during reset, then read address 0x00000004 with WAIT_CYCLES=2 -> waitrequest high exactly 3 cycles, low 1 cycle; readdata = 0x24032468 in that cycle.
2. Preload 0xFFFFFFFF at 0x08, write 0x12345678 with byteenable 4'b0101, then read 0x08 -> 0xFF34FF78.
3. Write 0xAAAA5555 to 0x0C, then immediately read 0x0C in the next cycle -> each access is 4 cycles and readdata = 0xAAAA5555; repeat with WAIT_CYCLES=0 -> waitrequest high 1 cycle per access.
4. Assert read and write together at 0x10 -> waitrequest stays high, protocol_error = 1, memory unchanged; drop read, keep write -> completes normally, protocol_error remains 1.
5. Start a write of 0xDEADBEEF to 0x14 holding 0x00000000, assert reset in the WAIT cycle -> word still 0x00000000, readdata = 0, protocol_error = 0, state IDLE.
6. Bus write 0x11111111 and preload 0x22222222 both targeting word 0x18 on the same DONE edge -> subsequent read returns 0x22222222.
